// File: rtl/pulse_stretch_pkg.sv
// pulse_stretch_pkg: shared states, defaults and index-width helper
package pulse_stretch_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, STRETCH = 2'd1, GAP = 2'd2} state_e;
    localparam int DEF_NCH = 4;
    localparam int DEF_CW = 8;
    localparam int DEF_DEF_LEN = 5;
    function automatic int chw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    localparam int DEF_CHW = chw(DEF_NCH);
endpackage

// File: rtl/pulse_stretch_core.sv
// pulse_stretch_core: load/decrement stretch engine with a one-cycle trailing gap
module pulse_stretch_core
    import pulse_stretch_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [CW-1:0] len_i,
    output logic          pulse_out_o,
    output logic          done_o
);
    state_e        state_q;
    logic [CW-1:0] cnt_q;

    // Engine FSM; a zero length is loaded as one so the counter never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    cnt_q   <= (len_i == '0) ? CW'(1) : len_i;
                    state_q <= STRETCH;
                end
                STRETCH: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= GAP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pulse_out_o = (state_q == STRETCH);
    assign done_o      = (state_q == GAP);
endmodule

// File: rtl/pulse_stretch_sched.sv
// pulse_stretch_sched: round-robin sharing of one pulse-stretch engine across channels
module pulse_stretch_sched
    import pulse_stretch_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int CW = DEF_CW,
    parameter int DEF_LEN = DEF_DEF_LEN,
    localparam int CHW = chw(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] pulse_in_i,
    input  logic           cfg_we_i,
    input  logic [CHW-1:0] cfg_ch_i,
    input  logic [CW-1:0]  cfg_len_i,
    output logic           pulse_out_o,
    output logic [CHW-1:0] out_ch_o,
    output logic [NCH-1:0] ack_o,
    output logic [NCH-1:0] drop_o,
    output logic           busy_o
);
    logic [NCH-1:0] pulse_in_q, pending_q, drop_q, pend_set, ack;
    logic [CW-1:0]  len_q [NCH];
    logic [CHW-1:0] rr_q, out_ch_q, gnt_idx, idx;
    logic           gnt_ok, grant, eng_pulse, eng_done;

    assign pend_set = pulse_in_i & ~pulse_in_q;
    assign busy_o   = eng_pulse | eng_done;
    assign grant    = ~busy_o & gnt_ok;
    assign ack      = grant ? (NCH'(1) << gnt_idx) : '0;

    // Round-robin pick: scan downward so the closest pending channel at or after rr_q wins
    always_comb begin
        gnt_ok  = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = CHW'((int'(rr_q) + k) % NCH);
            if (pending_q[idx]) begin
                gnt_ok  = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    // Edge history, pending set/clear, drop strobes, owner tag and rr pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_in_q <= '0;
            pending_q  <= '0;
            drop_q     <= '0;
            rr_q       <= '0;
            out_ch_q   <= '0;
        end else begin
            pulse_in_q <= pulse_in_i;
            pending_q  <= (pending_q & ~ack) | pend_set;
            drop_q     <= pend_set & pending_q & ~ack;
            if (grant) begin
                out_ch_q <= gnt_idx;
                rr_q     <= (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + CHW'(1);
            end
        end
    end

    // Per-channel stretch lengths; out-of-range channel writes are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) len_q[i] <= CW'(DEF_LEN);
        end else if (cfg_we_i && int'(cfg_ch_i) < NCH) begin
            len_q[cfg_ch_i] <= cfg_len_i;
        end
    end

    pulse_stretch_core #(.CW(CW)) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (grant),
        .len_i      (len_q[gnt_idx]),
        .pulse_out_o(eng_pulse),
        .done_o     (eng_done)
    );

    assign pulse_out_o = eng_pulse;
    assign out_ch_o    = out_ch_q;
    assign ack_o       = ack;
    assign drop_o      = drop_q;
endmodule

// File: tb/tb_pulse_stretch_sched.sv
// tb_pulse_stretch_sched: directed checks of grant order, widths, drops, config and reset
module tb_pulse_stretch_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] pulse_in_i = '0;
    logic       cfg_we_i = 1'b0;
    logic [1:0] cfg_ch_i = '0;
    logic [7:0] cfg_len_i = '0;
    logic       pulse_out_o, busy_o;
    logic [1:0] out_ch_o;
    logic [3:0] ack_o, drop_o, ack_any;
    int n_cmp = 0;
    int n_err = 0;
    int drop_cnt [4];

    pulse_stretch_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pulse_in_i (pulse_in_i),
        .cfg_we_i   (cfg_we_i),
        .cfg_ch_i   (cfg_ch_i),
        .cfg_len_i  (cfg_len_i),
        .pulse_out_o(pulse_out_o),
        .out_ch_o   (out_ch_o),
        .ack_o      (ack_o),
        .drop_o     (drop_o),
        .busy_o     (busy_o)
    );

    always #10 clk = ~clk;

    // Tally drop strobes per channel, sampled away from the active edge
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (drop_o[i] === 1'b1) drop_cnt[i]++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] m);
        pulse_in_i = m;
        @(negedge clk);
        pulse_in_i = '0;
    endtask

    task automatic measure(input string tag, input int exp_ch, input int exp_len);
        int w;
        logic [1:0] ch;
        w = 0;
        ch = out_ch_o;
        while (pulse_out_o === 1'b1 && w < 300) begin
            w++;
            @(negedge clk);
        end
        chk({tag, " width"}, w, exp_len);
        chk({tag, " out_ch"}, {30'd0, ch}, exp_ch);
        chk({tag, " gap busy"}, {31'd0, busy_o}, 1);
    endtask

    task automatic grant(input string tag, input int exp_ch, input int exp_len, input int exp_wait);
        int k;
        k = 0;
        while (ack_o === 4'd0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " ack"}, {28'd0, ack_o}, 1 << exp_ch);
        chk({tag, " wait"}, k, exp_wait);
        @(negedge clk);
        measure(tag, exp_ch, exp_len);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst pulse_out", {31'd0, pulse_out_o}, 0);
        chk("rst busy", {31'd0, busy_o}, 0);
        chk("rst ack", {28'd0, ack_o}, 0);
        chk("rst drop", {28'd0, drop_o}, 0);
        chk("rst out_ch", {30'd0, out_ch_o}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        // 1: single ch0 pulse, default length
        pulse(4'b0001);
        chk("t1 ack", {28'd0, ack_o}, 1);
        chk("t1 busy at grant", {31'd0, busy_o}, 0);
        @(negedge clk);
        measure("t1", 0, 5);
        @(negedge clk);
        chk("t1 busy after gap", {31'd0, busy_o}, 0);
        // 2: len[2]=3, len[1]=0, simultaneous ch1/ch2
        cfg_we_i = 1'b1; cfg_ch_i = 2'd2; cfg_len_i = 8'd3;
        @(negedge clk);
        cfg_ch_i = 2'd1; cfg_len_i = 8'd0;
        @(negedge clk);
        cfg_we_i = 1'b0;
        pulse(4'b0110);
        grant("t2 ch1", 1, 1, 0);
        grant("t2 ch2", 2, 3, 1);
        // 3: two full bursts after reset, strict 0..3 order
        do_reset();
        pulse(4'b1111);
        grant("t3a ch0", 0, 5, 0);
        grant("t3a ch1", 1, 5, 1);
        grant("t3a ch2", 2, 5, 1);
        grant("t3a ch3", 3, 5, 1);
        pulse(4'b1111);
        grant("t3b ch0", 0, 5, 0);
        grant("t3b ch1", 1, 5, 1);
        grant("t3b ch2", 2, 5, 1);
        grant("t3b ch3", 3, 5, 1);
        chk("t3 no drops", drop_cnt[0] + drop_cnt[1] + drop_cnt[2] + drop_cnt[3], 0);
        // 4: ch3 double edge while ch0 stretches
        pulse(4'b0001);
        chk("t4 ack ch0", {28'd0, ack_o}, 1);
        pulse_in_i = 4'b1000;
        @(negedge clk);
        pulse_in_i = '0;
        chk("t4 stretching", {31'd0, pulse_out_o}, 1);
        @(negedge clk);
        pulse_in_i = 4'b1000;
        @(negedge clk);
        pulse_in_i = '0;
        chk("t4 drop strobe", {28'd0, drop_o}, 32'h8);
        @(negedge clk);
        chk("t4 drop one cycle", {28'd0, drop_o}, 0);
        grant("t4 ch3", 3, 5, 3);
        ack_any = '0;
        repeat (10) begin
            @(negedge clk);
            ack_any |= ack_o;
        end
        chk("t4 single stretch", {28'd0, ack_any}, 0);
        chk("t4 drop count", drop_cnt[3], 1);
        chk("t4 idle", {31'd0, busy_o}, 0);
        // 5: length write during a stretch only affects the next grant
        pulse(4'b0001);
        chk("t5 ack", {28'd0, ack_o}, 1);
        @(negedge clk);
        chk("t5 first high", {31'd0, pulse_out_o}, 1);
        cfg_we_i = 1'b1; cfg_ch_i = 2'd0; cfg_len_i = 8'd2;
        @(negedge clk);
        cfg_we_i = 1'b0;
        measure("t5 cur", 0, 4);
        pulse(4'b0001);
        grant("t5 next", 0, 2, 0);
        // 6: reset in the third high cycle of an 8-cycle ch1 stretch, ch2 left pending
        cfg_we_i = 1'b1; cfg_ch_i = 2'd1; cfg_len_i = 8'd8;
        pulse(4'b0110);
        cfg_we_i = 1'b0;
        chk("t6 ack ch1", {28'd0, ack_o}, 32'h2);
        repeat (3) @(negedge clk);
        chk("t6 third high", {31'd0, pulse_out_o}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 async pulse_out", {31'd0, pulse_out_o}, 0);
        chk("t6 async busy", {31'd0, busy_o}, 0);
        chk("t6 async out_ch", {30'd0, out_ch_o}, 0);
        chk("t6 async ack", {28'd0, ack_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_any = '0;
        repeat (10) begin
            @(negedge clk);
            ack_any |= ack_o;
        end
        chk("t6 pending cleared", {28'd0, ack_any}, 0);
        pulse_in_i = 4'b0010;
        @(negedge clk);
        chk("t6 level ack", {28'd0, ack_o}, 32'h2);
        @(negedge clk);
        measure("t6 default len", 1, 5);
        ack_any = '0;
        repeat (8) begin
            @(negedge clk);
            ack_any |= ack_o;
        end
        chk("t6 level counts once", {28'd0, ack_any}, 0);
        pulse_in_i = '0;
        chk("t6 total drops", drop_cnt[0] + drop_cnt[1] + drop_cnt[2] + drop_cnt[3], 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
